// File: rtl/sc_mir_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_mir_pipe_if : handshake and decoded-field bundle for sc_mir_pipe  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sc_mir_pipe_if #(
  parameter int REG_AW  = 6,
  parameter int ALU_W   = 4,
  parameter int COND_W  = 3,
  parameter int JADDR_W = 11,
  parameter int WAIT_W  = 8
);
  localparam int MIR_DATAWIDTH = 3*REG_AW + 5 + ALU_W + COND_W + JADDR_W;

  logic [MIR_DATAWIDTH-1:0] SC_MIRPIPE_data_InBUS;
  logic                     SC_MIRPIPE_valid_In;
  logic                     SC_MIRPIPE_ready_Out;
  logic                     SC_MIRPIPE_advance_In;
  logic                     SC_MIRPIPE_MemDone_In;
  logic                     SC_MIRPIPE_flush_In;
  logic                     SC_MIRPIPE_valid_Out;
  logic [REG_AW-1:0]        SC_MIRPIPE_A_OutBUS;
  logic [REG_AW-1:0]        SC_MIRPIPE_B_OutBUS;
  logic [REG_AW-1:0]        SC_MIRPIPE_C_OutBUS;
  logic                     SC_MIRPIPE_AMUX_Out;
  logic                     SC_MIRPIPE_BMUX_Out;
  logic                     SC_MIRPIPE_CMUX_Out;
  logic                     SC_MIRPIPE_Read_Out;
  logic                     SC_MIRPIPE_Write_Out;
  logic [ALU_W-1:0]         SC_MIRPIPE_ALU_OutBUS;
  logic [COND_W-1:0]        SC_MIRPIPE_Cond_OutBUS;
  logic [JADDR_W-1:0]       SC_MIRPIPE_JumpAddr_OutBUS;
  logic [WAIT_W-1:0]        SC_MIRPIPE_WaitCount_OutBUS;

  modport master (
    output SC_MIRPIPE_data_InBUS, SC_MIRPIPE_valid_In, SC_MIRPIPE_advance_In,
           SC_MIRPIPE_MemDone_In, SC_MIRPIPE_flush_In,
    input  SC_MIRPIPE_ready_Out, SC_MIRPIPE_valid_Out,
           SC_MIRPIPE_A_OutBUS, SC_MIRPIPE_B_OutBUS, SC_MIRPIPE_C_OutBUS,
           SC_MIRPIPE_AMUX_Out, SC_MIRPIPE_BMUX_Out, SC_MIRPIPE_CMUX_Out,
           SC_MIRPIPE_Read_Out, SC_MIRPIPE_Write_Out, SC_MIRPIPE_ALU_OutBUS,
           SC_MIRPIPE_Cond_OutBUS, SC_MIRPIPE_JumpAddr_OutBUS,
           SC_MIRPIPE_WaitCount_OutBUS
  );

  modport slave (
    input  SC_MIRPIPE_data_InBUS, SC_MIRPIPE_valid_In, SC_MIRPIPE_advance_In,
           SC_MIRPIPE_MemDone_In, SC_MIRPIPE_flush_In,
    output SC_MIRPIPE_ready_Out, SC_MIRPIPE_valid_Out,
           SC_MIRPIPE_A_OutBUS, SC_MIRPIPE_B_OutBUS, SC_MIRPIPE_C_OutBUS,
           SC_MIRPIPE_AMUX_Out, SC_MIRPIPE_BMUX_Out, SC_MIRPIPE_CMUX_Out,
           SC_MIRPIPE_Read_Out, SC_MIRPIPE_Write_Out, SC_MIRPIPE_ALU_OutBUS,
           SC_MIRPIPE_Cond_OutBUS, SC_MIRPIPE_JumpAddr_OutBUS,
           SC_MIRPIPE_WaitCount_OutBUS
  );
endinterface
`default_nettype wire

// File: rtl/sc_mir_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_mir_pipe : microinstruction register, 2-entry elastic buffer,     |
// |               flush and memory wait-state counter. Rev 1.0           |
// +----------------------------------------------------------------------+
module sc_mir_pipe #(
  parameter int REG_AW  = 6,
  parameter int ALU_W   = 4,
  parameter int COND_W  = 3,
  parameter int JADDR_W = 11,
  parameter int WAIT_W  = 8
) (
  input  wire          SC_MIRPIPE_CLOCK_50,
  input  wire          SC_MIRPIPE_RESET_InLow,
  sc_mir_pipe_if.slave mir_if
);
  localparam int MIR_DATAWIDTH = 3*REG_AW + 5 + ALU_W + COND_W + JADDR_W;

  localparam int COND_LSB = JADDR_W;
  localparam int ALU_LSB  = COND_LSB + COND_W;
  localparam int WR_BIT   = ALU_LSB + ALU_W;
  localparam int RD_BIT   = WR_BIT + 1;
  localparam int CMUX_BIT = RD_BIT + 1;
  localparam int C_LSB    = CMUX_BIT + 1;
  localparam int BMUX_BIT = C_LSB + REG_AW;
  localparam int B_LSB    = BMUX_BIT + 1;
  localparam int AMUX_BIT = B_LSB + REG_AW;
  localparam int A_LSB    = AMUX_BIT + 1;

  localparam logic [WAIT_W-1:0] WCNT_MAX = {WAIT_W{1'b1}};

  logic [MIR_DATAWIDTH-1:0] out_word_q, out_word_d;
  logic                     out_v_q,    out_v_d;
  logic [MIR_DATAWIDTH-1:0] skid_word_q, skid_word_d;
  logic                     skid_v_q,    skid_v_d;
  logic [WAIT_W-1:0]        wcnt_q,      wcnt_d;

  logic memop, fire, ready, accept;

  // An empty OUT always holds the zero word, so memop is 0 when nothing is valid.
  assign memop  = out_word_q[RD_BIT] | out_word_q[WR_BIT];
  assign fire   = out_v_q & mir_if.SC_MIRPIPE_advance_In & (~memop | mir_if.SC_MIRPIPE_MemDone_In);
  assign ready  = ~skid_v_q;
  assign accept = mir_if.SC_MIRPIPE_valid_In & ready;

  always_comb begin
    out_word_d  = out_word_q;
    out_v_d     = out_v_q;
    skid_word_d = skid_word_q;
    skid_v_d    = skid_v_q;
    wcnt_d      = wcnt_q;

    if (mir_if.SC_MIRPIPE_flush_In) begin
      out_word_d = '0;
      out_v_d    = 1'b0;
      skid_v_d   = 1'b0;
      wcnt_d     = '0;
    end else if (!out_v_q || fire) begin
      wcnt_d = '0;
      if (skid_v_q) begin
        out_word_d = skid_word_q;
        out_v_d    = 1'b1;
        skid_v_d   = 1'b0;
      end else if (accept) begin
        out_word_d = mir_if.SC_MIRPIPE_data_InBUS;
        out_v_d    = 1'b1;
      end else begin
        out_word_d = '0;
        out_v_d    = 1'b0;
      end
    end else begin
      if (accept) begin
        skid_word_d = mir_if.SC_MIRPIPE_data_InBUS;
        skid_v_d    = 1'b1;
      end
      if (memop && !mir_if.SC_MIRPIPE_MemDone_In && wcnt_q != WCNT_MAX)
        wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge SC_MIRPIPE_CLOCK_50 or negedge SC_MIRPIPE_RESET_InLow) begin
    if (!SC_MIRPIPE_RESET_InLow) begin
      out_word_q  <= '0;
      out_v_q     <= 1'b0;
      skid_word_q <= '0;
      skid_v_q    <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      out_word_q  <= out_word_d;
      out_v_q     <= out_v_d;
      skid_word_q <= skid_word_d;
      skid_v_q    <= skid_v_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign mir_if.SC_MIRPIPE_ready_Out        = ready;
  assign mir_if.SC_MIRPIPE_valid_Out        = out_v_q;
  assign mir_if.SC_MIRPIPE_A_OutBUS         = out_word_q[A_LSB +: REG_AW];
  assign mir_if.SC_MIRPIPE_AMUX_Out         = out_word_q[AMUX_BIT];
  assign mir_if.SC_MIRPIPE_B_OutBUS         = out_word_q[B_LSB +: REG_AW];
  assign mir_if.SC_MIRPIPE_BMUX_Out         = out_word_q[BMUX_BIT];
  assign mir_if.SC_MIRPIPE_C_OutBUS         = out_word_q[C_LSB +: REG_AW];
  assign mir_if.SC_MIRPIPE_CMUX_Out         = out_word_q[CMUX_BIT];
  assign mir_if.SC_MIRPIPE_Read_Out         = out_word_q[RD_BIT];
  assign mir_if.SC_MIRPIPE_Write_Out        = out_word_q[WR_BIT];
  assign mir_if.SC_MIRPIPE_ALU_OutBUS       = out_word_q[ALU_LSB +: ALU_W];
  assign mir_if.SC_MIRPIPE_Cond_OutBUS      = out_word_q[COND_LSB +: COND_W];
  assign mir_if.SC_MIRPIPE_JumpAddr_OutBUS  = out_word_q[JADDR_W-1:0];
  assign mir_if.SC_MIRPIPE_WaitCount_OutBUS = wcnt_q;

endmodule
`default_nettype wire
